// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: shared definitions for the MMIO bus bridge.
//   ADDR_W  - CPU/device byte address width
//   state_t - transaction FSM encoding (IDLE, ACCESS, DONE, ERR)
package mmio_bus_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational address decoder.
//   addr    in  ADDR_W  CPU byte address
//   sel_idx out IDX_W   lowest-index device whose (addr & mask) == base
//   hit     out 1       at least one device matched
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter int unsigned                  NUM_DEV  = 6,
  parameter int unsigned                  IDX_W    = 3,
  parameter logic [NUM_DEV*ADDR_W-1:0]    DEV_BASE = '0,
  parameter logic [NUM_DEV*ADDR_W-1:0]    DEV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  sel_idx,
  output logic              hit
);

  logic [NUM_DEV-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      hit_vec[i] = (addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = NUM_DEV; i > 0; i--) begin
      if (hit_vec[i-1]) sel_idx = IDX_W'(i - 1);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: single-outstanding CPU-to-device MMIO bridge.
// Optional feature: define MMIO_BUS_TIMEOUT_EN to abort a device access
// after TIMEOUT_CYC cycles without dev_ready (reported as bus_err).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_addr/read/write/wdata/be  CPU request (held while bus_stall=1)
//   req_rdata                     read data, valid when stall drops after a read
//   bus_stall                     CPU must hold its request
//   bus_err                       one-cycle error pulse (unmapped / timeout)
//   dev_addr/wdata/be             latched request, shared by all devices
//   dev_re/dev_we                 one-hot strobes to the selected device
//   dev_rdata/dev_ready           packed device responses
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter int unsigned               NUM_DEV     = 6,
  parameter int unsigned               DATA_W      = 32,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE    = {32'h1FD00500, 32'h1FD00400, 32'h1FD003F0,
                                                      32'h1B000000, 32'h1E000000, 32'h00000000},
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK    = {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFF0,
                                                      32'hFF000000, 32'hFF000000, 32'hFF000000},
  parameter int unsigned               TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic                      req_read,
  input  logic                      req_write,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_be,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      bus_stall,
  output logic                      bus_err,
  output logic [ADDR_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  output logic [DATA_W/8-1:0]       dev_be,
  output logic [NUM_DEV-1:0]        dev_re,
  output logic [NUM_DEV-1:0]        dev_we,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_ready
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  state_t           state;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_hit;
  logic             req_any;

  assign req_any = req_read | req_write;

  mmio_addr_decode #(
    .NUM_DEV  (NUM_DEV),
    .IDX_W    (IDX_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr    (req_addr),
    .sel_idx (dec_idx),
    .hit     (dec_hit)
  );

  // Stall is combinational so the CPU is held in the same cycle it issues.
  assign bus_stall = (state == ACCESS) || (state == IDLE && req_any);

`ifdef MMIO_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  // TIMEOUT_CYC is kept for drop-in parameter compatibility only.
  if (TIMEOUT_CYC == 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
      dev_re    <= '0;
      dev_we    <= '0;
      bus_err   <= 1'b0;
      req_rdata <= '0;
`ifdef MMIO_BUS_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            if (dec_hit) begin
              dev_addr  <= req_addr;
              dev_wdata <= req_wdata;
              dev_be    <= req_be;
              sel_q     <= dec_idx;
              // Write takes precedence when both request lines are high.
              if (req_write) dev_we <= NUM_DEV'(1) << dec_idx;
              else           dev_re <= NUM_DEV'(1) << dec_idx;
`ifdef MMIO_BUS_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              state     <= ACCESS;
            end else begin
              bus_err   <= 1'b1;
              req_rdata <= '0;
              state     <= ERR;
            end
          end
        end
        ACCESS: begin
          if (dev_ready[sel_q]) begin
            // Access direction is recovered from which strobe is active.
            if (dev_we == '0) req_rdata <= dev_rdata[sel_q*DATA_W +: DATA_W];
            dev_re <= '0;
            dev_we <= '0;
            state  <= DONE;
          end
`ifdef MMIO_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            dev_re    <= '0;
            dev_we    <= '0;
            bus_err   <= 1'b1;
            req_rdata <= '0;
            state     <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed self-checking bench for mmio_bus.
// u_dut uses the default address map (TIMEOUT_CYC=4); u_ovl overlaps dev0
// and dev1 at 0x1E000000 to exercise lowest-index priority.
module tb_mmio_bus;

  logic         clk = 1'b0;
  logic         rst_n;

  logic [31:0]  req_addr;
  logic         req_read, req_write;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic [31:0]  req_rdata;
  logic         bus_stall, bus_err;
  logic [31:0]  dev_addr, dev_wdata;
  logic [3:0]   dev_be;
  logic [5:0]   dev_re, dev_we;
  logic [191:0] dev_rdata;
  logic [5:0]   dev_ready;

  logic [31:0]  o_addr;
  logic         o_read, o_write;
  logic [31:0]  o_wdata;
  logic [3:0]   o_be;
  logic [31:0]  o_rdata;
  logic         o_stall, o_err;
  logic [31:0]  o_dev_addr, o_dev_wdata;
  logic [3:0]   o_dev_be;
  logic [5:0]   o_dev_re, o_dev_we;
  logic [191:0] o_dev_rdata;
  logic [5:0]   o_dev_ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mmio_bus #(
    .NUM_DEV     (6),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_rdata (req_rdata),
    .bus_stall (bus_stall),
    .bus_err   (bus_err),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_be    (dev_be),
    .dev_re    (dev_re),
    .dev_we    (dev_we),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready)
  );

  mmio_bus #(
    .NUM_DEV  (6),
    .DATA_W   (32),
    .DEV_BASE ({32'h1FD00500, 32'h1FD00400, 32'h1FD003F0,
                32'h1B000000, 32'h1E000000, 32'h1E000000})
  ) u_ovl (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (o_addr),
    .req_read  (o_read),
    .req_write (o_write),
    .req_wdata (o_wdata),
    .req_be    (o_be),
    .req_rdata (o_rdata),
    .bus_stall (o_stall),
    .bus_err   (o_err),
    .dev_addr  (o_dev_addr),
    .dev_wdata (o_dev_wdata),
    .dev_be    (o_dev_be),
    .dev_re    (o_dev_re),
    .dev_we    (o_dev_we),
    .dev_rdata (o_dev_rdata),
    .dev_ready (o_dev_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_addr  = '0; req_read = 1'b0; req_write = 1'b0;
    req_wdata = '0; req_be   = '0;
    dev_ready = '0;
    dev_rdata = {32'h55550005, 32'h44440004, 32'h33330003,
                 32'h22220002, 32'hCAFEF00D, 32'h12345678};
    o_addr    = '0; o_read = 1'b0; o_write = 1'b0;
    o_wdata   = '0; o_be   = '0;
    o_dev_ready = '0;
    o_dev_rdata = {32'h0, 32'h0, 32'h0, 32'h0, 32'hBEEF0001, 32'hAAAA0000};

    // Reset state
    tick(); tick();
    check("rst_dev_re",    dev_re,    6'b0);
    check("rst_dev_we",    dev_we,    6'b0);
    check("rst_bus_err",   bus_err,   1'b0);
    check("rst_req_rdata", req_rdata, 32'h0);
    check("rst_dev_addr",  dev_addr,  32'h0);
    check("rst_bus_stall", bus_stall, 1'b0);
    rst_n = 1'b1;
    tick();

    // Read 0x00000010, dev0 ready immediately
    req_addr = 32'h00000010; req_read = 1'b1; dev_ready = 6'b000001;
    #1;
    check("rd0_idle_stall", bus_stall, 1'b1);
    check("rd0_idle_re",    dev_re,    6'b0);
    tick();
    check("rd0_acc_re",     dev_re,    6'b000001);
    check("rd0_acc_stall",  bus_stall, 1'b1);
    tick();
    check("rd0_done_re",    dev_re,    6'b0);
    check("rd0_done_stall", bus_stall, 1'b0);
    check("rd0_done_data",  req_rdata, 32'h12345678);
    check("rd0_done_err",   bus_err,   1'b0);
    req_read = 1'b0; dev_ready = '0;
    tick();
    check("rd0_idle_after", bus_stall, 1'b0);

    // Write 0x1FD003F8 (read also high: must be treated as write)
    req_addr = 32'h1FD003F8; req_wdata = 32'h41; req_be = 4'h1;
    req_write = 1'b1; req_read = 1'b1;
    #1;
    check("wr3_idle_stall", bus_stall, 1'b1);
    tick();
    check("wr3_we",    dev_we,    6'b001000);
    check("wr3_re",    dev_re,    6'b0);
    check("wr3_addr",  dev_addr,  32'h1FD003F8);
    check("wr3_wdata", dev_wdata, 32'h41);
    check("wr3_be",    dev_be,    4'h1);
    tick();
    check("wr3_we_hold",    dev_we,    6'b001000);
    check("wr3_stall_hold", bus_stall, 1'b1);
    dev_ready = 6'b001000;
    tick();
    check("wr3_done_we",    dev_we,    6'b0);
    check("wr3_done_stall", bus_stall, 1'b0);
    check("wr3_done_rdata", req_rdata, 32'h12345678);
    req_write = 1'b0; req_read = 1'b0; dev_ready = '0;
    tick();

    // Unmapped read 0x30000000
    req_addr = 32'h30000000; req_read = 1'b1;
    #1;
    check("un_idle_stall", bus_stall, 1'b1);
    tick();
    check("un_err",   bus_err,   1'b1);
    check("un_stall", bus_stall, 1'b0);
    check("un_rdata", req_rdata, 32'h0);
    check("un_re",    dev_re,    6'b0);
    check("un_we",    dev_we,    6'b0);
    req_read = 1'b0;
    tick();
    check("un_err_pulse", bus_err, 1'b0);

    // Read 0x1B000000 (dev2), reset asserted mid-access
    req_addr = 32'h1B000000; req_read = 1'b1;
    tick();
    check("ra_re_c1", dev_re, 6'b000100);
    tick();
    check("ra_re_c2", dev_re, 6'b000100);
    rst_n = 1'b0;
    tick();
    check("ra_re_rst",    dev_re,    6'b0);
    check("ra_err_rst",   bus_err,   1'b0);
    check("ra_rdata_rst", req_rdata, 32'h0);
    rst_n = 1'b1; req_read = 1'b0; dev_ready = 6'b000100;
    #1;
    check("ra_stall_idle", bus_stall, 1'b0);
    tick();
    check("ra_no_err",   bus_err,   1'b0);
    check("ra_no_done",  req_rdata, 32'h0);
    check("ra_re_idle",  dev_re,    6'b0);
    dev_ready = '0;

    // 0x1E000004: default map -> dev1; overlapping map -> dev0 only
    req_addr = 32'h1E000004; req_read = 1'b1;
    o_addr   = 32'h1E000004; o_read   = 1'b1;
    tick();
    check("ov_dut_re", dev_re,   6'b000010);
    check("ov_ovl_re", o_dev_re, 6'b000001);
    dev_ready = 6'b000010; o_dev_ready = 6'b000001;
    tick();
    check("ov_dut_data", req_rdata, 32'hCAFEF00D);
    check("ov_ovl_data", o_rdata,   32'hAAAA0000);
    req_read = 1'b0; o_read = 1'b0; dev_ready = '0; o_dev_ready = '0;
    tick();

    // Read 0x1FD00404 (dev4), device never ready
    req_addr = 32'h1FD00404; req_read = 1'b1;
`ifdef MMIO_BUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_re_c%0d", i), dev_re, 6'b010000);
    end
    tick();
    check("to_err",   bus_err,   1'b1);
    check("to_rdata", req_rdata, 32'h0);
    check("to_re",    dev_re,    6'b0);
    check("to_stall", bus_stall, 1'b0);
    req_read = 1'b0;
    tick();
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("wait_re_c%0d", i), dev_re, 6'b010000);
    end
    check("wait_stall", bus_stall, 1'b1);
    check("wait_err",   bus_err,   1'b0);
    dev_ready = 6'b010000;
    tick();
    check("wait_data",  req_rdata, 32'h44440004);
    check("wait_stall_done", bus_stall, 1'b0);
    req_read = 1'b0; dev_ready = '0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 SHALL have parameter NUM_DEV, default 6, number of device ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter DEV_BASE, default {0x1FD00500,0x1FD00400,0x1FD003F0,0x1B000000,0x1E000000,0x00000000}, packed NUM_DEV x 32 base addresses, index 0 in LSBs.
REQ-004 SHALL have parameter DEV_MASK, default {0xFFFFFF00,0xFFFFFF00,0xFFFFFFF0,0xFF000000,0xFF000000,0xFF000000}, packed NUM_DEV x 32 compare masks.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255, device-wait limit in cycles.
REQ-006 SHALL provide ports:
 clk  in  1  clock; sole clock, rising edge.
 rst_n  in  1  reset; synchronous, active-low.
 req_addr  in  32  CPU byte address.
 req_read  in  1  read request.
 req_write  in  1  write request.
 req_wdata  in  DATA_W  write data.
 req_be  in  DATA_W/8  byte enables.
 req_rdata  out  DATA_W  read data, valid while bus_stall=0 following a read.
 bus_stall  out  1  CPU must hold request stable while high.
 bus_err  out  1  one-cycle error pulse.
 dev_addr  out  32  latched address, shared by all devices.
 dev_wdata  out  DATA_W  latched write data, shared.
 dev_be  out  DATA_W/8  latched byte enables, shared.
 dev_re  out  NUM_DEV  one-hot read strobe.
 dev_we  out  NUM_DEV  one-hot write strobe.
 dev_rdata  in  NUM_DEV x DATA_W  packed device read data.
 dev_ready  in  NUM_DEV  device completion, sampled only for the selected index.

Function
REQ-007 Hit for device i SHALL be (req_addr & DEV_MASK[i]) == DEV_BASE[i]; multiple hits SHALL select the lowest index.
REQ-008 FSM states SHALL be IDLE, ACCESS, DONE, ERR.
REQ-009 IDLE: request (req_read|req_write) with hit SHALL latch addr/wdata/be/index, go ACCESS; bus_stall=1 combinationally this cycle.
REQ-010 IDLE: request with no hit SHALL go ERR; bus_stall=1 this cycle; no device strobe ever asserted.
REQ-011 req_read and req_write both high SHALL be a write; read ignored.
REQ-012 ACCESS: exactly one dev_re or dev_we bit high (selected index), bus_stall=1, strobes stable until ready.
REQ-013 ACCESS with dev_ready[sel]=1 SHALL register dev_rdata[sel] into req_rdata (reads only) and go DONE; strobes drop on that edge.
REQ-014 DONE: bus_stall=0, req_rdata holds captured value, next state IDLE; minimum read latency SHALL be 2 stall cycles, data on third cycle.
REQ-015 ERR: bus_stall=0, bus_err=1, req_rdata=0, next state IDLE.
REQ-016 Only one transaction outstanding; requests in ACCESS/DONE/ERR SHALL not be sampled.
REQ-017 req_rdata SHALL hold its value outside DONE/ERR; only its value in DONE/ERR is defined to the CPU.

Reset
REQ-018 rst_n=0 at a rising edge SHALL force IDLE, dev_re=dev_we=0, bus_err=0, req_rdata=0, dev_addr=dev_wdata=dev_be=0, timeout counter=0.
REQ-019 Reset during ACCESS SHALL abandon the transaction; strobes low from the next edge; no DONE/ERR issued.
REQ-020 After reset release bus_stall SHALL depend only on IDLE request decode.

Configuration
REQ-021 With MMIO_BUS_TIMEOUT_EN defined, a counter SHALL clear on entering ACCESS and increment each ACCESS cycle; when it reaches TIMEOUT_CYC without ready, strobes drop and FSM goes ERR.
REQ-022 Without MMIO_BUS_TIMEOUT_EN, no counter SHALL exist and ACCESS waits indefinitely for dev_ready.

Structure
REQ-023 Shared package mmio_bus_pkg SHALL hold the state encoding and address-width constant.
REQ-024 Decode SHALL be sub-module mmio_addr_decode (combinational hit vector, priority index, hit flag); mmio_bus holds FSM, latches, counter.

Verification
REQ-025 Read 0x00000010, dev0 ready immediately, dev_rdata[0]=0x12345678 -> dev_re=0b000001 one cycle, stall 2 cycles, req_rdata=0x12345678, bus_err=0.
REQ-026 Write 0x1FD003F8 data 0x41 be=0x1 -> dev_we=0b001000, dev_addr=0x1FD003F8, dev_wdata=0x41, dev_be=0x1 until ready.
REQ-027 Read 0x30000000 (unmapped) -> 1 stall cycle, bus_err pulse, req_rdata=0, no strobes.
REQ-028 With MMIO_BUS_TIMEOUT_EN, TIMEOUT_CYC=4, dev4 never ready, read 0x1FD00404 -> dev_re[4] for 4 cycles, then bus_err, req_rdata=0.
REQ-029 Read 0x1B000000, dev2 ready after 3 cycles, rst_n=0 on cycle 2 -> strobe low after reset edge, IDLE, no bus_err.
REQ-030 Overlapping bases (dev0 and dev1 both 0x1E000000) read 0x1E000004 -> dev_re=0b000001 only.
